// File: rtl/baud_gen_frac.sv
// Fractional baud generator: os_tick every div_int + div_frac/2^FRAC_W clocks,
// bit_tick on every OVERSAMPLE-th os_tick. Divisor updates apply on period boundaries.
module baud_gen_frac #(
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned FRAC_W       = 4,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DEF_DIV_INT  = 54,
  parameter int unsigned DEF_DIV_FRAC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              restart,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              div_pending,
  output logic              os_tick,
  output logic              bit_tick
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);

  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_int_q;
  logic [DIV_W-1:0]  pend_int;
  logic [DIV_W-1:0]  deff;
  logic [DIV_W-1:0]  term;
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] div_frac_q;
  logic [FRAC_W-1:0] pend_frac;
  logic [FRAC_W:0]   acc_sum;
  logic              extra;
  logic [OS_W-1:0]   os_cnt;
  logic              terminal;
  logic              apply;

  always_comb begin
    deff     = (div_int_q == '0) ? DIV_W'(1) : div_int_q;
    term     = deff - DIV_W'(1) + {{(DIV_W-1){1'b0}}, extra};
    acc_sum  = {1'b0, acc} + {1'b0, div_frac_q};
    // >= rather than == so a shorter divisor applied while frozen can never
    // leave cnt stranded above the terminal and wrap around.
    terminal = en && (cnt >= term);
    apply    = div_pending && (!en || terminal);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      extra       <= 1'b0;
      os_cnt      <= '0;
      div_int_q   <= DIV_W'(DEF_DIV_INT);
      div_frac_q  <= FRAC_W'(DEF_DIV_FRAC);
      pend_int    <= '0;
      pend_frac   <= '0;
      div_pending <= 1'b0;
      os_tick     <= 1'b0;
      bit_tick    <= 1'b0;
    end else if (restart) begin
      cnt         <= '0;
      acc         <= '0;
      extra       <= 1'b0;
      os_cnt      <= '0;
      os_tick     <= 1'b0;
      bit_tick    <= 1'b0;
      div_pending <= 1'b0;
      if (div_load) begin
        div_int_q  <= div_int;
        div_frac_q <= div_frac;
      end else if (div_pending) begin
        div_int_q  <= pend_int;
        div_frac_q <= pend_frac;
      end
    end else begin
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      if (en) begin
        if (terminal) begin
          cnt            <= '0;
          os_tick        <= 1'b1;
          {extra, acc}   <= acc_sum;
          if (os_cnt == OS_W'(OVERSAMPLE - 1)) begin
            os_cnt   <= '0;
            bit_tick <= 1'b1;
          end else begin
            os_cnt <= os_cnt + OS_W'(1);
          end
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
      if (apply) begin
        div_int_q   <= pend_int;
        div_frac_q  <= pend_frac;
        div_pending <= 1'b0;
      end
      // A load in the same cycle as an apply re-arms pending with the new value.
      if (div_load) begin
        pend_int    <= div_int;
        pend_frac   <= div_frac;
        div_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: expected tick times come from the closed form
// t_k = k*Deff + floor((k-1)*frac/16), queued and matched against observed ticks.
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        restart;
  logic        div_load;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_pending;
  logic        os_tick;
  logic        bit_tick;

  int errors = 0;
  int checks = 0;
  int os_q[$];
  int bit_q[$];
  int first_seen;
  int seen_cnt;

  typedef struct {
    int unsigned di;
    int unsigned df;
    int          window;
    int          exp_first;
    int          exp_count;
  } vec_t;

  vec_t vecs[8];

  baud_gen_frac #(
    .DIV_W(16), .FRAC_W(4), .OVERSAMPLE(16), .DEF_DIV_INT(54), .DEF_DIV_FRAC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(restart), .div_load(div_load),
    .div_int(div_int), .div_frac(div_frac), .div_pending(div_pending),
    .os_tick(os_tick), .bit_tick(bit_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_expect(input int base, input int unsigned deff,
                             input int unsigned df, input int limit);
    int t;
    for (int k = 1; k < 100000; k++) begin
      t = base + k * int'(deff) + ((k - 1) * int'(df)) / 16;
      if (t > limit) break;
      os_q.push_back(t);
      if (k % 16 == 0) bit_q.push_back(t);
    end
  endtask

  task automatic sample_check(input int idx);
    if (os_tick) begin
      seen_cnt++;
      if (first_seen < 0) first_seen = idx;
      if (os_q.size() == 0) chk("os_unexpected", idx, -1);
      else chk("os_time", idx, os_q.pop_front());
    end
    if (bit_tick) begin
      if (bit_q.size() == 0) chk("bit_unexpected", idx, -1);
      else chk("bit_time", idx, bit_q.pop_front());
    end
  endtask

  task automatic end_window();
    chk("os_missing", os_q.size(), 0);
    chk("bit_missing", bit_q.size(), 0);
    os_q.delete();
    bit_q.delete();
  endtask

  // Called just after a negedge; returns at the negedge of relative cycle 0.
  task automatic start(input bit load, input int unsigned di, input int unsigned df);
    restart  = 1'b1;
    div_load = load;
    div_int  = di[15:0];
    div_frac = df[3:0];
    en       = 1'b1;
    @(negedge clk);
    restart  = 1'b0;
    div_load = 1'b0;
  endtask

  task automatic run_window(input int n, input int unsigned deff, input int unsigned df,
                            input int exp_first, input int exp_count);
    first_seen = -1;
    seen_cnt   = 0;
    chk("pending_after_restart", int'(div_pending), 0);
    push_expect(0, deff, df, n);
    for (int idx = 0; idx <= n; idx++) begin
      sample_check(idx);
      @(negedge clk);
    end
    chk("first_tick", first_seen, exp_first);
    chk("tick_count", seen_cnt, exp_count);
    end_window();
  endtask

  initial begin
    vecs[0] = '{di: 4, df: 0,  window: 140, exp_first: 4, exp_count: 35};
    vecs[1] = '{di: 4, df: 8,  window: 160, exp_first: 4, exp_count: 35};
    vecs[2] = '{di: 0, df: 0,  window: 20,  exp_first: 1, exp_count: 20};
    vecs[3] = '{di: 1, df: 0,  window: 20,  exp_first: 1, exp_count: 20};
    vecs[4] = '{di: 1, df: 8,  window: 30,  exp_first: 1, exp_count: 20};
    vecs[5] = '{di: 3, df: 5,  window: 100, exp_first: 3, exp_count: 30};
    vecs[6] = '{di: 7, df: 15, window: 200, exp_first: 7, exp_count: 25};
    vecs[7] = '{di: 2, df: 1,  window: 80,  exp_first: 2, exp_count: 39};

    rst_n = 1'b0; en = 1'b0; restart = 1'b0; div_load = 1'b0;
    div_int = '0; div_frac = '0;
    repeat (3) @(negedge clk);
    chk("reset_os_tick", int'(os_tick), 0);
    chk("reset_bit_tick", int'(bit_tick), 0);
    chk("reset_pending", int'(div_pending), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Load while frozen: applied on the following cycle.
    div_load = 1'b1; div_int = 16'd5; div_frac = 4'd0;
    @(negedge clk);
    chk("frozen_pending_set", int'(div_pending), 1);
    div_load = 1'b0;
    @(negedge clk);
    chk("frozen_pending_clear", int'(div_pending), 0);
    start(1'b0, 0, 0);
    run_window(30, 5, 0, 5, 6);

    foreach (vecs[i]) begin
      start(1'b1, vecs[i].di, vecs[i].df);
      run_window(vecs[i].window, (vecs[i].di == 0) ? 1 : vecs[i].di, vecs[i].df,
                 vecs[i].exp_first, vecs[i].exp_count);
    end

    // Load 6.0 mid-period of a 4-period: that period stays 4, then 6.
    start(1'b1, 4, 0);
    os_q = '{4, 10, 16};
    for (int idx = 0; idx <= 20; idx++) begin
      sample_check(idx);
      if (idx == 1) begin div_load = 1'b1; div_int = 16'd6; div_frac = 4'd0; end
      if (idx == 2) begin div_load = 1'b0; chk("load_pending_2", int'(div_pending), 1); end
      if (idx == 3) chk("load_pending_3", int'(div_pending), 1);
      if (idx == 4) chk("load_pending_apply", int'(div_pending), 0);
      @(negedge clk);
    end
    end_window();

    // Freeze 10 cycles at cnt=2, resume, then restart at cnt=2.
    start(1'b1, 4, 0);
    os_q = '{14, 21, 25, 29};
    for (int idx = 0; idx <= 30; idx++) begin
      sample_check(idx);
      if (idx == 2)  en = 1'b0;
      if (idx == 12) en = 1'b1;
      if (idx == 16) restart = 1'b1;
      if (idx == 17) restart = 1'b0;
      @(negedge clk);
    end
    end_window();

    // Reset mid-period with a pending divisor: defaults (54 + 4/16) restored.
    start(1'b1, 4, 0);
    push_expect(3, 54, 4, 300);
    for (int idx = 0; idx <= 300; idx++) begin
      sample_check(idx);
      if (idx == 1) begin div_load = 1'b1; div_int = 16'd9; div_frac = 4'd0; end
      if (idx == 2) begin
        div_load = 1'b0;
        chk("rst_pending_before", int'(div_pending), 1);
        rst_n = 1'b0;
      end
      if (idx == 3) begin
        chk("rst_os_tick", int'(os_tick), 0);
        chk("rst_bit_tick", int'(bit_tick), 0);
        chk("rst_pending_after", int'(div_pending), 0);
        rst_n = 1'b1;
      end
      @(negedge clk);
    end
    end_window();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
